sensor_poll_scheduler: RTL and testbench

Sequences one shared UART sensor link (one request byte out, one 16-bit checksummed response in) between an autonomous round-robin poller and a host port driven by a Nios custom instruction. It issues requests through the uart_tx handshake, waits for the response with a timeout, verifies the checksum and retries on failure. It keeps the latest value and status per sensor in a result table that the host reads without waiting on the link.

---
 rtl/sensor_poll_scheduler.sv | 251 +++++++++++++++++++++++++
 tb/tb_sensor_poll_scheduler.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_poll_scheduler.sv
// Purpose: shares one UART sensor link between a round-robin poller and a host port, keeping a per-sensor result table.
// Latency: host accept -> tx_start next cycle; rx_valid -> table write / host_ack two cycles later; out-of-range host -> ack next cycle.
// Backpressure: one transaction at a time; host_req is held until host_ack, tx_byte holds until tx_done, rd_data is always available.
module sensor_poll_scheduler #(
    parameter int          NUM_SENSORS     = 8,
    parameter int          TIMEOUT_CYCLES  = 500000000,
    parameter int          POLL_GAP_CYCLES = 50000,
    parameter int          MAX_RETRY       = 2,
    parameter logic [7:0]  CHECK_KEY       = 8'h37
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [NUM_SENSORS-1:0] sensor_mask,
    output logic                   tx_start,
    output logic [7:0]             tx_byte,
    input  logic                   tx_done,
    input  logic                   rx_valid,
    input  logic [15:0]            rx_data,
    input  logic                   host_req,
    input  logic [7:0]             host_addr,
    output logic                   host_ack,
    output logic [15:0]            host_data,
    input  logic [4:0]             rd_addr,
    output logic [15:0]            rd_data,
    output logic                   busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_TX,
        S_WAIT_RX,
        S_CHECK,
        S_STORE,
        S_GAP
    } state_t;

    state_t       state_q,     state_d;
    logic [4:0]   idx_q,       idx_d;        // sensor of the current transaction
    logic [4:0]   rr_last_q,   rr_last_d;    // last auto-polled sensor
    logic         is_host_q,   is_host_d;
    logic         range_err_q, range_err_d;
    logic [7:0]   attempt_q,   attempt_d;    // requests sent in this transaction
    logic [31:0]  tmo_cnt_q,   tmo_cnt_d;
    logic [31:0]  gap_cnt_q,   gap_cnt_d;
    logic [15:0]  rx_q,        rx_d;
    logic [10:0]  entry_q,     entry_d;      // table entry written in STORE
    logic [7:0]   tx_byte_q,   tx_byte_d;
    logic [15:0]  host_data_q, host_data_d;
    logic [15:0]  rd_data_q;

    // Table is sized for the full 5-bit index; entries at or above NUM_SENSORS are never written.
    logic [10:0]  tbl_q [32];

    logic [31:0]  mask_ext;
    logic         auto_found;
    logic [4:0]   auto_idx;
    logic [5:0]   cand;
    logic         good_rsp;
    logic [10:0]  old_entry;
    logic         fail_now;
    logic         fail_tmo;

    assign mask_ext  = 32'(sensor_mask);
    assign good_rsp  = (rx_q[15:8] == (rx_q[7:0] ^ CHECK_KEY));
    assign old_entry = tbl_q[idx_q];

    assign tx_start  = (state_q == S_SEND);
    assign tx_byte   = tx_byte_q;
    assign host_ack  = (state_q == S_STORE) && is_host_q;
    assign host_data = host_data_q;
    assign rd_data   = rd_data_q;
    assign busy      = (state_q != S_IDLE) && (state_q != S_GAP);

    // Round robin: first set mask bit strictly after the last auto-polled index, wrapping.
    always_comb begin
        auto_found = 1'b0;
        auto_idx   = '0;
        cand       = '0;
        for (int k = 1; k <= NUM_SENSORS; k++) begin
            cand = {1'b0, rr_last_q} + 6'(k);
            if (cand >= 6'(NUM_SENSORS)) begin
                cand = cand - 6'(NUM_SENSORS);
            end
            if (!auto_found && mask_ext[cand[4:0]]) begin
                auto_found = 1'b1;
                auto_idx   = cand[4:0];
            end
        end
    end

    // Next-state and datapath updates for the transaction sequencer.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        rr_last_d   = rr_last_q;
        is_host_d   = is_host_q;
        range_err_d = range_err_q;
        attempt_d   = attempt_q;
        tmo_cnt_d   = tmo_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        rx_d        = rx_q;
        entry_d     = entry_q;
        tx_byte_d   = tx_byte_q;
        host_data_d = host_data_q;
        fail_now    = 1'b0;
        fail_tmo    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (host_req) begin
                    is_host_d = 1'b1;
                    attempt_d = '0;
                    if (host_addr >= 8'(NUM_SENSORS)) begin
                        range_err_d = 1'b1;
                        host_data_d = 16'h8000;
                        state_d     = S_STORE;
                    end else begin
                        range_err_d = 1'b0;
                        idx_d       = host_addr[4:0];
                        tx_byte_d   = {3'b000, host_addr[4:0]} + 8'd1;
                        state_d     = S_SEND;
                    end
                end else if (enable && auto_found) begin
                    is_host_d   = 1'b0;
                    range_err_d = 1'b0;
                    attempt_d   = '0;
                    idx_d       = auto_idx;
                    rr_last_d   = auto_idx;
                    tx_byte_d   = {3'b000, auto_idx} + 8'd1;
                    state_d     = S_SEND;
                end
            end
            S_SEND: begin
                // tx_byte was loaded on entry so it is valid alongside tx_start.
                attempt_d = attempt_q + 8'd1;
                state_d   = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                if (tx_done) begin
                    tmo_cnt_d = '0;
                    state_d   = S_WAIT_RX;
                end
            end
            S_WAIT_RX: begin
                // A response in the expiry cycle takes priority over the timeout.
                if (rx_valid) begin
                    rx_d    = rx_data;
                    state_d = S_CHECK;
                end else if (tmo_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    fail_now = 1'b1;
                    fail_tmo = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 32'd1;
                end
            end
            S_CHECK: begin
                if (good_rsp) begin
                    entry_d = {2'b00, 1'b1, rx_q[7:0]};
                    state_d = S_STORE;
                end else begin
                    fail_now = 1'b1;
                end
            end
            S_STORE: begin
                gap_cnt_d = '0;
                state_d   = S_GAP;
            end
            S_GAP: begin
                if (host_req || (gap_cnt_q + 32'd1 >= 32'(POLL_GAP_CYCLES))) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Failed attempt: retry the same sensor (tx_byte unchanged) or give up keeping the old value.
        if (fail_now) begin
            if (attempt_q < 8'(MAX_RETRY + 1)) begin
                state_d = S_SEND;
            end else begin
                entry_d = {~fail_tmo, fail_tmo, old_entry[8:0]};
                state_d = S_STORE;
            end
        end

        // Host result is presented from the first STORE cycle.
        if ((state_d == S_STORE) && is_host_d && !range_err_d && (state_q != S_STORE)) begin
            host_data_d = {5'b00000, entry_d};
        end
    end

    // Sequencer state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            rr_last_q   <= 5'(NUM_SENSORS - 1);
            is_host_q   <= 1'b0;
            range_err_q <= 1'b0;
            attempt_q   <= '0;
            tmo_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            rx_q        <= '0;
            entry_q     <= '0;
            tx_byte_q   <= '0;
            host_data_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rr_last_q   <= rr_last_d;
            is_host_q   <= is_host_d;
            range_err_q <= range_err_d;
            attempt_q   <= attempt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            rx_q        <= rx_d;
            entry_q     <= entry_d;
            tx_byte_q   <= tx_byte_d;
            host_data_q <= host_data_d;
        end
    end

    // Result table: cleared on reset, written once per completed in-range transaction.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                tbl_q[i] <= '0;
            end
        end else if ((state_q == S_STORE) && !range_err_q) begin
            tbl_q[idx_q] <= entry_q;
        end
    end

    // Registered table read port; out-of-range indices read as zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if ({1'b0, rd_addr} < 6'(NUM_SENSORS)) begin
            rd_data_q <= {5'b00000, tbl_q[rd_addr]};
        end else begin
            rd_data_q <= '0;
        end
    end

endmodule

// File: tb/tb_sensor_poll_scheduler.sv
// Purpose: scoreboard bench for sensor_poll_scheduler with directed host, auto-poll, retry and timeout vectors.
// Latency: expected tx bytes and host results are queued by stimulus and popped by a negedge monitor.
// Backpressure: the bench plays uart_tx/uart_rx and the host, holding host_req until host_ack.
module tb_sensor_poll_scheduler;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [7:0]  sensor_mask = '0;
    logic        tx_start;
    logic [7:0]  tx_byte;
    logic        tx_done = 1'b0;
    logic        rx_valid = 1'b0;
    logic [15:0] rx_data = '0;
    logic        host_req = 1'b0;
    logic [7:0]  host_addr = '0;
    logic        host_ack;
    logic [15:0] host_data;
    logic [4:0]  rd_addr = '0;
    logic [15:0] rd_data;
    logic        busy;

    int total = 0;
    int bad   = 0;
    logic [7:0]  exp_tx  [$];
    logic [15:0] exp_ack [$];

    always #5 clock = ~clock;

    sensor_poll_scheduler #(
        .NUM_SENSORS(8),
        .TIMEOUT_CYCLES(100),
        .POLL_GAP_CYCLES(10),
        .MAX_RETRY(2),
        .CHECK_KEY(8'h37)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .sensor_mask(sensor_mask),
        .tx_start(tx_start),
        .tx_byte(tx_byte),
        .tx_done(tx_done),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .host_req(host_req),
        .host_addr(host_addr),
        .host_ack(host_ack),
        .host_data(host_data),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every tx_start and host_ack must match the head of its expectation queue.
    always @(negedge clock) begin
        if (!reset) begin
            if (tx_start) begin
                chk("tx_expected", 32'(exp_tx.size() != 0), 32'd1);
                if (exp_tx.size() != 0) chk("tx_byte", 32'(tx_byte), 32'(exp_tx.pop_front()));
            end
            if (host_ack) begin
                chk("ack_with_req", 32'(host_req), 32'd1);
                chk("ack_expected", 32'(exp_ack.size() != 0), 32'd1);
                if (exp_ack.size() != 0) chk("host_data", 32'(host_data), 32'(exp_ack.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_tx();
        int n = 0;
        while (!tx_start && n < 2000) begin
            tick();
            n++;
        end
        chk("tx_seen", 32'(tx_start), 32'd1);
    endtask

    // From the SEND cycle: one WAIT_TX cycle with tx_done, returning in the first WAIT_RX cycle.
    task automatic do_tx_done();
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic respond(input logic [15:0] d, input int delay);
        repeat (delay) tick();
        rx_valid = 1'b1;
        rx_data  = d;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        while (!host_ack && n < 1000) begin
            tick();
            n++;
        end
        chk("ack_seen", 32'(host_ack), 32'd1);
        tick();
        host_req = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [4:0] a, input logic [15:0] exp);
        rd_addr = a;
        tick();
        chk(name, 32'(rd_data), 32'(exp));
    endtask

    function automatic logic [15:0] good(input logic [7:0] v);
        return {v ^ 8'h37, v};
    endfunction

    initial begin
        int n;
        logic [7:0] seq_b [4];
        logic [7:0] vals  [4];
        seq_b = '{8'd3, 8'd6, 8'd8, 8'd3};
        vals  = '{8'h10, 8'h11, 8'h12, 8'h13};

        repeat (3) tick();
        reset = 1'b0;
        chk("rst_tx_start", 32'(tx_start), 0);
        chk("rst_tx_byte", 32'(tx_byte), 0);
        chk("rst_host_ack", 32'(host_ack), 0);
        chk("rst_host_data", 32'(host_data), 0);
        chk("rst_busy", 32'(busy), 0);
        rd_chk("rst_rd0", 5'd0, 16'h0000);

        // Host-only read of sensor 2 with enable low.
        exp_tx.push_back(8'd3);
        exp_ack.push_back(16'h017A);
        host_addr = 8'd2;
        host_req  = 1'b1;
        tick();
        chk("host_tx_latency", 32'(tx_start), 32'd1);
        do_tx_done();
        respond(16'h4D7A, 2);
        chk("ack_not_early", 32'(host_ack), 0);
        wait_ack(n);
        chk("ack_two_after_rx", 32'(n), 32'd1);
        rd_chk("tbl2_after_host", 5'd2, 16'h017A);
        repeat (15) tick();

        // Auto round robin over sensors 2,5,7.
        sensor_mask = 8'b1010_0100;
        exp_tx.push_back(seq_b[0]);
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) exp_tx.push_back(seq_b[i]);
            wait_tx();
            if (i == 3) enable = 1'b0;
            do_tx_done();
            respond(good(vals[i]), 1);
        end
        repeat (20) tick();
        chk("auto_idle", 32'(busy), 0);
        rd_chk("tbl2_auto", 5'd2, 16'h0113);
        rd_chk("tbl5_auto", 5'd5, 16'h0111);
        rd_chk("tbl7_auto", 5'd7, 16'h0112);
        rd_chk("tbl0_unpolled", 5'd0, 16'h0000);
        rd_chk("rd_out_of_range", 5'd20, 16'h0000);

        // Bad checksum then good retry on sensor 4.
        exp_tx.push_back(8'd5);
        exp_tx.push_back(8'd5);
        exp_ack.push_back(16'h017A);
        host_addr = 8'd4;
        host_req  = 1'b1;
        wait_tx();
        do_tx_done();
        respond(16'h007A, 1);
        wait_tx();
        do_tx_done();
        respond(16'h4D7A, 1);
        wait_ack(n);
        rd_chk("tbl4_retry", 5'd4, 16'h017A);
        repeat (15) tick();

        // No response on sensor 5: three attempts of exactly 100 WAIT_RX cycles each.
        exp_tx.push_back(8'd6);
        exp_tx.push_back(8'd6);
        exp_tx.push_back(8'd6);
        exp_ack.push_back(16'h0311);
        host_addr = 8'd5;
        host_req  = 1'b1;
        wait_tx();
        for (int a = 0; a < 2; a++) begin
            do_tx_done();
            n = 0;
            while (!tx_start && n < 500) begin
                tick();
                n++;
            end
            chk("wait_rx_len_retry", 32'(n), 32'd100);
        end
        do_tx_done();
        wait_ack(n);
        chk("wait_rx_len_last", 32'(n), 32'd100);
        rd_chk("tbl5_timeout", 5'd5, 16'h0311);
        repeat (15) tick();

        // rx_valid in the expiry cycle wins; then a stray rx_valid during GAP.
        exp_tx.push_back(8'd8);
        exp_ack.push_back(16'h0155);
        host_addr = 8'd7;
        host_req  = 1'b1;
        wait_tx();
        do_tx_done();
        respond(good(8'h55), 99);
        wait_ack(n);
        chk("expiry_ack_timing", 32'(n), 32'd1);
        rx_valid = 1'b1;
        rx_data  = 16'h0000;
        tick();
        rx_valid = 1'b0;
        repeat (15) tick();
        rd_chk("tbl7_stray", 5'd7, 16'h0155);

        // Out-of-range host address.
        exp_ack.push_back(16'h8000);
        host_addr = 8'd9;
        host_req  = 1'b1;
        tick();
        chk("range_ack_next", 32'(host_ack), 32'd1);
        tick();
        host_req = 1'b0;
        repeat (15) tick();

        // Reset during WAIT_RX aborts with no ack and clears the table.
        exp_tx.push_back(8'd2);
        host_addr = 8'd1;
        host_req  = 1'b1;
        wait_tx();
        do_tx_done();
        repeat (5) tick();
        reset    = 1'b1;
        host_req = 1'b0;
        tick();
        reset = 1'b0;
        chk("post_reset_busy", 32'(busy), 0);
        repeat (20) tick();
        rd_chk("tbl2_cleared", 5'd2, 16'h0000);
        rd_chk("tbl5_cleared", 5'd5, 16'h0000);

        chk("tx_queue_drained", 32'(exp_tx.size()), 0);
        chk("ack_queue_drained", 32'(exp_ack.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
